axi_noid_ram: RTL and testbench

AXI4 slave memory with no ID signals, serving the ID-less master port that sits downstream of the team's AXI ID-stripping logic. It accepts one read burst and one write burst at a time, with the read and write channels independent of each other. It answers every burst strictly in order, which matches what the ID-stripping side expects. Storage is an internal register array, and the block serves as the bench and simulation target for ID-less AXI paths.

---
 rtl/axi_noid_ram_if.sv | 57 +++++
 rtl/axi_noid_ram.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_noid_ram.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_noid_ram_if.sv
// ID-less AXI4 bus bundle: one master/slave pair carrying AW, W, B, AR and R channels.
interface axi_noid_ram_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input  rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_noid_ram.sv
// ID-less AXI4 slave memory: independent single-outstanding read and write bursts,
// answered in order, backed by an internal word array.
module axi_noid_ram #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_WORDS  = 1024
) (
    input  logic          aclk,
    input  logic          aresetn,
    axi_noid_ram_if.slave s_axi
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int B      = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [IDX_W-1:0]      idx_t;
    typedef struct packed {
        logic [2:0] size;
        logic [1:0] burst;
        logic       err;
    } desc_t;

    typedef enum logic [0:0] {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    function automatic idx_t word_idx(input addr_t a);
        return a[IDX_W+B-1:B];
    endfunction

    function automatic addr_t next_addr(input addr_t a, input logic [2:0] size,
                                        input logic [7:0] len, input logic [1:0] burst);
        addr_t s;
        addr_t mask;
        s    = addr_t'(1) << size;
        mask = ((addr_t'(len) + addr_t'(1)) * s) - addr_t'(1);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + s) & mask);
            default: return (a & ~(s - addr_t'(1))) + s;
        endcase
    endfunction

    // Unsupported descriptors are degraded to something safe and flagged for SLVERR.
    function automatic desc_t check_desc(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
        desc_t d;
        d.size  = size;
        d.burst = burst;
        d.err   = 1'b0;
        if (size > 3'(B)) begin
            d.size = 3'(B);
            d.err  = 1'b1;
        end
        if (burst == 2'b11) begin
            d.burst = 2'b01;
            d.err   = 1'b1;
        end else if (burst == 2'b10 &&
                     !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            d.burst = 2'b01;
            d.err   = 1'b1;
        end
        return d;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    r_state_t   r_state_q, r_state_d;
    addr_t      raddr_q, raddr_d, raddr_next;
    logic [7:0] rcnt_q, rcnt_d, rlen_q, rlen_d;
    logic [2:0] rsize_q, rsize_d;
    logic [1:0] rburst_q, rburst_d;
    logic       rerr_q, rerr_d, rlast_q, rlast_d;
    logic       rd_fetch;
    idx_t       rd_idx;
    desc_t      ar_desc;

    w_state_t   w_state_q, w_state_d;
    addr_t      waddr_q, waddr_d;
    logic [7:0] wcnt_q, wcnt_d, wlen_q, wlen_d;
    logic [2:0] wsize_q, wsize_d;
    logic [1:0] wburst_q, wburst_d;
    logic       werr_q, werr_d;
    logic       wr_en;
    idx_t       wr_idx;
    desc_t      aw_desc;

    assign ar_desc    = check_desc(s_axi.arlen, s_axi.arsize, s_axi.arburst);
    assign aw_desc    = check_desc(s_axi.awlen, s_axi.awsize, s_axi.awburst);
    assign raddr_next = next_addr(raddr_q, rsize_q, rlen_q, rburst_q);
    assign wr_idx     = word_idx(waddr_q);

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rcnt_d    = rcnt_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rerr_d    = rerr_q;
        rlast_d   = rlast_q;
        rd_fetch  = 1'b0;
        rd_idx    = word_idx(raddr_next);
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    raddr_d   = s_axi.araddr;
                    rcnt_d    = s_axi.arlen;
                    rlen_d    = s_axi.arlen;
                    rsize_d   = ar_desc.size;
                    rburst_d  = ar_desc.burst;
                    rerr_d    = ar_desc.err;
                    rlast_d   = (s_axi.arlen == 8'd0);
                    rd_fetch  = 1'b1;
                    rd_idx    = word_idx(s_axi.araddr);
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (s_axi.rready) begin
                    raddr_d = raddr_next;
                    rcnt_d  = rcnt_q - 8'd1;
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rlast_d  = (rcnt_q == 8'd1);
                        rd_fetch = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        waddr_d   = waddr_q;
        wcnt_d    = wcnt_q;
        wlen_d    = wlen_q;
        wsize_d   = wsize_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid) begin
                    waddr_d   = s_axi.awaddr;
                    wcnt_d    = s_axi.awlen;
                    wlen_d    = s_axi.awlen;
                    wsize_d   = aw_desc.size;
                    wburst_d  = aw_desc.burst;
                    werr_d    = aw_desc.err;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.wvalid) begin
                    wr_en   = 1'b1;
                    waddr_d = next_addr(waddr_q, wsize_q, wlen_q, wburst_q);
                    wcnt_d  = wcnt_q - 8'd1;
                    // awlen alone decides the burst end; wlast only feeds the error flag.
                    if (s_axi.wlast != (wcnt_q == 8'd0)) werr_d = 1'b1;
                    if (wcnt_q == 8'd0) w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            raddr_q   <= '0;
            rcnt_q    <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rerr_q    <= 1'b0;
            rlast_q   <= 1'b0;
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wcnt_q    <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            werr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rcnt_q    <= rcnt_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rerr_q    <= rerr_d;
            rlast_q   <= rlast_d;
            w_state_q <= w_state_d;
            waddr_q   <= waddr_d;
            wcnt_q    <= wcnt_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            werr_q    <= werr_d;
        end
    end

    // Read data is prefetched on the handshake that selects the word, so a same-edge
    // write is seen one cycle later and rdata holds steady through any stall.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
        if (rd_fetch) rdata_q <= mem[rd_idx];
    end

    assign s_axi.arready = (r_state_q == R_IDLE);
    assign s_axi.rvalid  = (r_state_q == R_BURST);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = {rerr_q, 1'b0};
    assign s_axi.rlast   = rlast_q;
    assign s_axi.awready = (w_state_q == W_IDLE);
    assign s_axi.wready  = (w_state_q == W_DATA);
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bresp   = {werr_q, 1'b0};

    logic unused_sideband;
    assign unused_sideband = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                               s_axi.awregion, s_axi.arlock, s_axi.arcache, s_axi.arprot,
                               s_axi.arqos, s_axi.arregion};
endmodule

// File: tb/tb_axi_noid_ram.sv
// Scoreboard bench for axi_noid_ram: expected read beats are queued when a burst is
// requested and popped as the DUT delivers them.
module tb_axi_noid_ram;
    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    axi_noid_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s_axi ();

    axi_noid_ram #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_WORDS(1024)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axi   (s_axi)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    rbeat_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic push_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
        exp_q.push_back({d, r, l});
    endtask

    task automatic push_incr(input logic [63:0] d0, input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) push_beat(d0 + 64'(i), r, (i == n - 1));
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [15:0] rpat, input string tag,
                            output int first_k, output int last_k, output time hs_t);
        int          k, got, wait_c;
        logic        stalled;
        logic [63:0] held;
        rbeat_t      e;
        @(negedge aclk);
        s_axi.araddr  = addr;
        s_axi.arlen   = len;
        s_axi.arsize  = size;
        s_axi.arburst = burst;
        s_axi.arvalid = 1'b1;
        wait_c = 0;
        while (!s_axi.arready && wait_c < 50) begin
            @(negedge aclk);
            wait_c++;
        end
        hs_t = $time;
        @(negedge aclk);
        s_axi.arvalid = 1'b0;
        k = 1; got = 0; stalled = 1'b0; held = '0; first_k = -1; last_k = -1;
        while (got <= int'(len) && k < 200) begin
            s_axi.rready = rpat[(k - 1) % 16];
            if (s_axi.rvalid) begin
                if (first_k < 0) first_k = k;
                if (stalled) begin
                    n_vec++;
                    if (s_axi.rdata !== held) begin
                        n_err++;
                        $display("FAIL %s stall_hold beat %0d: got %h want %h", tag, got, s_axi.rdata, held);
                    end
                end
                if (s_axi.rready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL %s beat %0d: got %h/%0d/%0d want nothing queued", tag, got,
                                 s_axi.rdata, s_axi.rresp, s_axi.rlast);
                    end else begin
                        e = exp_q.pop_front();
                        if ({s_axi.rdata, s_axi.rresp, s_axi.rlast} !== e) begin
                            n_err++;
                            $display("FAIL %s beat %0d: got data=%h resp=%0d last=%0d want data=%h resp=%0d last=%0d",
                                     tag, got, s_axi.rdata, s_axi.rresp, s_axi.rlast, e.data, e.resp, e.last);
                        end
                    end
                    got++;
                    stalled = 1'b0;
                    last_k = k;
                end else begin
                    stalled = 1'b1;
                    held = s_axi.rdata;
                end
            end
            @(negedge aclk);
            k++;
        end
        s_axi.rready = 1'b0;
        if (got <= int'(len)) begin
            n_vec++;
            n_err++;
            $display("FAIL %s read_timeout: got %0d beats want %0d", tag, got, int'(len) + 1);
        end
        $display("read  %s addr=%h len=%0d beats=%0d first_k=%0d last_k=%0d", tag, addr, len, got, first_k, last_k);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] strb,
                             input int wl_mode, input string tag,
                             output logic [1:0] resp, output int b_k, output time hs_t);
        int k, beat, wait_c;
        @(negedge aclk);
        s_axi.awaddr  = addr;
        s_axi.awlen   = len;
        s_axi.awsize  = size;
        s_axi.awburst = burst;
        s_axi.awvalid = 1'b1;
        wait_c = 0;
        while (!s_axi.awready && wait_c < 50) begin
            @(negedge aclk);
            wait_c++;
        end
        hs_t = $time;
        @(negedge aclk);
        s_axi.awvalid = 1'b0;
        k = 1; beat = 0;
        while (beat <= int'(len) && k < 200) begin
            s_axi.wvalid = 1'b1;
            s_axi.wdata  = d0 + 64'(beat);
            s_axi.wstrb  = strb;
            case (wl_mode)
                0:       s_axi.wlast = (beat == int'(len));
                1:       s_axi.wlast = (beat == 1);
                default: s_axi.wlast = 1'b0;
            endcase
            if (s_axi.wready) beat++;
            @(negedge aclk);
            k++;
        end
        s_axi.wvalid = 1'b0;
        s_axi.wlast  = 1'b0;
        s_axi.bready = 1'b1;
        b_k = -1;
        resp = 2'bxx;
        while (k < 200 && b_k < 0) begin
            if (s_axi.bvalid) begin
                b_k = k;
                resp = s_axi.bresp;
            end
            @(negedge aclk);
            k++;
        end
        s_axi.bready = 1'b0;
        if (b_k < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s b_timeout: got no bvalid want bvalid", tag);
        end
        $display("write %s addr=%h len=%0d beats=%0d bresp=%0d b_k=%0d", tag, addr, len, beat, resp, b_k);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        s_axi.awvalid = 0; s_axi.awaddr = 0; s_axi.awlen = 0; s_axi.awsize = 0; s_axi.awburst = 0;
        s_axi.awlock = 0; s_axi.awcache = 0; s_axi.awprot = 0; s_axi.awqos = 0; s_axi.awregion = 0;
        s_axi.wvalid = 0; s_axi.wdata = 0; s_axi.wstrb = 0; s_axi.wlast = 0; s_axi.bready = 0;
        s_axi.arvalid = 0; s_axi.araddr = 0; s_axi.arlen = 0; s_axi.arsize = 0; s_axi.arburst = 0;
        s_axi.arlock = 0; s_axi.arcache = 0; s_axi.arprot = 0; s_axi.arqos = 0; s_axi.arregion = 0;
        s_axi.rready = 0;
        repeat (2) @(negedge aclk);
        n_vec++;
        if ({s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.rlast, s_axi.bvalid,
             s_axi.rresp, s_axi.bresp} !== 10'b11_0000_0000) begin
            n_err++;
            $display("FAIL reset_outputs: got ar=%b aw=%b w=%b rv=%b rl=%b bv=%b rresp=%0d bresp=%0d want 1 1 0 0 0 0 0 0",
                     s_axi.arready, s_axi.awready, s_axi.wready, s_axi.rvalid, s_axi.rlast,
                     s_axi.bvalid, s_axi.rresp, s_axi.bresp);
        end
        aresetn = 1'b1;
        @(negedge aclk);
        $display("reset released");
    endtask

    task automatic test_write_read();
        logic [1:0] resp;
        int bk, fk, lk;
        time t;
        axi_write(32'h100, 8'd3, 3'd3, 2'b01, 64'hA0, 8'hFF, 0, "wr_incr", resp, bk, t);
        n_vec++;
        if (resp !== 2'b00 || bk != 5) begin
            n_err++;
            $display("FAIL wr_incr_b: got bresp=%0d b_k=%0d want bresp=0 b_k=5", resp, bk);
        end
        push_incr(64'hA0, 2'b00, 4);
        axi_read(32'h100, 8'd3, 3'd3, 2'b01, 16'hFFFF, "rd_incr", fk, lk, t);
        n_vec++;
        if (fk != 1 || lk != 4) begin
            n_err++;
            $display("FAIL rd_incr_timing: got first=%0d last=%0d want first=1 last=4", fk, lk);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] resp;
        int bk, fk, lk;
        time t;
        axi_write(32'h120, 8'd1, 3'd3, 2'b01, 64'hB0, 8'hFF, 0, "wr_b", resp, bk, t);
        push_beat(64'hA3, 2'b00, 1'b0);
        push_beat(64'hA0, 2'b00, 1'b0);
        push_beat(64'hA1, 2'b00, 1'b0);
        push_beat(64'hA2, 2'b00, 1'b1);
        axi_read(32'h118, 8'd3, 3'd3, 2'b10, 16'hFFFF, "rd_wrap4", fk, lk, t);
        push_beat(64'hA3, 2'b10, 1'b0);
        push_beat(64'hB0, 2'b10, 1'b0);
        push_beat(64'hB1, 2'b10, 1'b1);
        axi_read(32'h118, 8'd2, 3'd3, 2'b10, 16'hFFFF, "rd_wrap_bad", fk, lk, t);
        push_incr(64'hA0, 2'b10, 2);
        axi_read(32'h100, 8'd1, 3'd3, 2'b11, 16'hFFFF, "rd_rsvd", fk, lk, t);
        push_beat(64'hA0, 2'b10, 1'b1);
        axi_read(32'h100, 8'd0, 3'd4, 2'b01, 16'hFFFF, "rd_big_size", fk, lk, t);
    endtask

    task automatic test_narrow();
        logic [1:0] resp;
        int bk, fk, lk;
        time t;
        axi_write(32'h200, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "wr_full", resp, bk, t);
        axi_write(32'h200, 8'd0, 3'd2, 2'b01, 64'h0000_0000_1234_5678, 8'h0F, 0, "wr_narrow", resp, bk, t);
        n_vec++;
        if (resp !== 2'b00) begin
            n_err++;
            $display("FAIL wr_narrow_b: got bresp=%0d want 0", resp);
        end
        push_beat(64'hFFFF_FFFF_1234_5678, 2'b00, 1'b1);
        axi_read(32'h200, 8'd0, 3'd3, 2'b01, 16'hFFFF, "rd_narrow", fk, lk, t);
    endtask

    task automatic test_wlast();
        logic [1:0] resp;
        int bk, fk, lk;
        time t;
        axi_write(32'h400, 8'd3, 3'd3, 2'b01, 64'hC0, 8'hFF, 1, "wr_early_last", resp, bk, t);
        n_vec++;
        if (resp !== 2'b10 || bk != 5) begin
            n_err++;
            $display("FAIL wr_early_last_b: got bresp=%0d b_k=%0d want bresp=2 b_k=5", resp, bk);
        end
        push_incr(64'hC0, 2'b00, 4);
        axi_read(32'h400, 8'd3, 3'd3, 2'b01, 16'hFFFF, "rd_early_last", fk, lk, t);
        axi_write(32'h420, 8'd0, 3'd3, 2'b01, 64'hC8, 8'hFF, 2, "wr_no_last", resp, bk, t);
        n_vec++;
        if (resp !== 2'b10 || bk != 2) begin
            n_err++;
            $display("FAIL wr_no_last_b: got bresp=%0d b_k=%0d want bresp=2 b_k=2", resp, bk);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp;
        int bk, fk, lk;
        time t;
        axi_write(32'h500, 8'd7, 3'd3, 2'b01, 64'hD0, 8'hFF, 0, "wr_d", resp, bk, t);
        push_incr(64'hD0, 2'b00, 8);
        axi_read(32'h500, 8'd7, 3'd3, 2'b01, 16'b1001_1001_1001_1001, "rd_stall", fk, lk, t);
    endtask

    task automatic test_concurrent();
        logic [1:0] resp_a, resp_b;
        int bk_a, bk_b, fk_a, lk_a, fk_b, lk_b;
        time taw, tar, t2;
        push_incr(64'hA0, 2'b00, 4);
        fork
            axi_write(32'h600, 8'd1, 3'd3, 2'b01, 64'hE0, 8'hFF, 0, "wr_conc", resp_a, bk_a, taw);
            axi_read(32'h100, 8'd3, 3'd3, 2'b01, 16'hFFFF, "rd_conc", fk_a, lk_a, tar);
        join
        n_vec++;
        if (taw != tar || bk_a != 3 || resp_a !== 2'b00) begin
            n_err++;
            $display("FAIL conc_accept: got aw_t=%0t ar_t=%0t b_k=%0d bresp=%0d want equal times b_k=3 bresp=0",
                     taw, tar, bk_a, resp_a);
        end
        axi_write(32'h300, 8'd0, 3'd3, 2'b01, 64'h11, 8'hFF, 0, "wr_old", resp_b, bk_b, t2);
        push_beat(64'h11, 2'b00, 1'b1);
        fork
            axi_write(32'h300, 8'd0, 3'd3, 2'b01, 64'h55, 8'hFF, 0, "wr_new", resp_b, bk_b, taw);
            begin
                @(negedge aclk);
                axi_read(32'h300, 8'd0, 3'd3, 2'b01, 16'hFFFF, "rd_same_cycle", fk_b, lk_b, tar);
            end
        join
        n_vec++;
        if (tar - taw != 10) begin
            n_err++;
            $display("FAIL same_cycle_align: got ar-aw=%0t want 10", tar - taw);
        end
        push_beat(64'h55, 2'b00, 1'b1);
        axi_read(32'h300, 8'd0, 3'd3, 2'b01, 16'hFFFF, "rd_after_write", fk_b, lk_b, t2);
    endtask

    task automatic test_reset_mid_burst();
        int  fk, lk;
        time t;
        logic [63:0] want;
        @(negedge aclk);
        s_axi.araddr = 32'h500; s_axi.arlen = 8'd7; s_axi.arsize = 3'd3; s_axi.arburst = 2'b01;
        s_axi.arvalid = 1'b1;
        s_axi.awaddr = 32'h700; s_axi.awlen = 8'd7; s_axi.awsize = 3'd3; s_axi.awburst = 2'b01;
        s_axi.awvalid = 1'b1;
        @(negedge aclk);
        s_axi.arvalid = 1'b0; s_axi.awvalid = 1'b0;
        s_axi.rready = 1'b1;
        s_axi.wvalid = 1'b1; s_axi.wdata = 64'hF0; s_axi.wstrb = 8'hFF; s_axi.wlast = 1'b0;
        for (int b = 0; b < 2; b++) begin
            want = 64'hD0 + 64'(b);
            n_vec++;
            if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== want) begin
                n_err++;
                $display("FAIL rst_pre_beat%0d: got rv=%b data=%h want rv=1 data=%h", b, s_axi.rvalid, s_axi.rdata, want);
            end
            @(negedge aclk);
        end
        aresetn = 1'b0;
        #1;
        n_vec++;
        if ({s_axi.rvalid, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.awready} !== 5'b00011) begin
            n_err++;
            $display("FAIL rst_mid_drop: got rv=%b wr=%b bv=%b ar=%b aw=%b want 0 0 0 1 1",
                     s_axi.rvalid, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.awready);
        end
        s_axi.rready = 1'b0;
        s_axi.wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_vec++;
        if ({s_axi.arready, s_axi.awready, s_axi.rvalid, s_axi.wready} !== 4'b1100) begin
            n_err++;
            $display("FAIL rst_mid_release: got ar=%b aw=%b rv=%b wr=%b want 1 1 0 0",
                     s_axi.arready, s_axi.awready, s_axi.rvalid, s_axi.wready);
        end
        $display("reset mid-burst done");
        push_incr(64'hD0, 2'b00, 8);
        axi_read(32'h500, 8'd7, 3'd3, 2'b01, 16'hFFFF, "rd_post_reset", fk, lk, t);
        n_vec++;
        if (fk != 1 || lk != 8) begin
            n_err++;
            $display("FAIL rd_post_reset_timing: got first=%0d last=%0d want first=1 last=8", fk, lk);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_narrow();
        test_wlast();
        test_backpressure();
        test_concurrent();
        test_reset_mid_burst();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover beats want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "watchdog expired");
    end
endmodule
